// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_grant_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } rr_state_e;

    // Successor of idx in a ring of n requesters.
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_ctrl_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;
    logic               forced;

    modport master (output req, input gnt, gnt_idx, busy, forced);
    modport slave  (input req, output gnt, gnt_idx, busy, forced);
endinterface

// File: rtl/rr_grant_ctrl_pick.sv
// Combinational rotate-priority picker: first asserted request scanning up from prio_i, wrapping.
module rr_pick
    import rr_grant_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   prio_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = prio_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
            cand = IDX_W'(rr_next_idx(int'(cand), NUM_REQ));
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin hold-until-release arbiter with a per-grant hold limit.
// Optional embedded properties: define RR_GRANT_CTRL_ASSERTIONS_EN.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_grant_ctrl_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    rr_state_e          state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   prio_q, prio_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               forced_q, forced_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req),
        .prio_i  (prio_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            prio_q    <= '0;
            hold_q    <= '0;
            forced_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            prio_q    <= prio_d;
            hold_q    <= hold_d;
            forced_q  <= forced_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        prio_d    = prio_q;
        hold_d    = hold_q;
        forced_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = GRANT;
                    gnt_d     = NUM_REQ'(1) << pick_idx;
                    gnt_idx_d = pick_idx;
                    hold_d    = HOLD_W'(1);
                end
            end
            GRANT: begin
                // A dropped request takes precedence over the hold limit, so forced stays low.
                if (!bus.req[gnt_idx_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
                    forced_d  = bus.req[gnt_idx_q];
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    hold_d    = '0;
                    prio_d    = IDX_W'(rr_next_idx(int'(gnt_idx_q), NUM_REQ));
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.busy    = |gnt_q;
    assign bus.forced  = forced_q;

`ifdef RR_GRANT_CTRL_ASSERTIONS_EN
    default clocking cb @(posedge clk); endclocking
    default disable iff (!rst_n);

    a_onehot:   assert property ($onehot0(gnt_q));
    a_req_prev: assert property ((gnt_q & ~$past(bus.req)) == '0);
    a_idle_go:  assert property ((state_q == IDLE && |bus.req) |=> bus.busy);
    a_forced:   assert property (forced_q |-> $past(bus.busy));
    a_hold:     assert property (bus.busy |-> hold_q <= HOLD_W'(MAX_HOLD));
    c_forced:   cover property (forced_q);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cov
        c_gnt: cover property (gnt_q[g]);
    end
`else
    // Properties compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed scenarios plus randomized requests against a cycle model.
module tb_rr_grant_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rr_grant_ctrl_if #(.NUM_REQ(N)) bus ();

    rr_grant_ctrl #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 = none), age of the current grant, one dead cycle after a release, pointer.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    bit m_dead  = 1'b0;
    bit m_forced = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int n_owner, n_age, n_ptr, c;
        bit n_dead, n_forced;
        n_owner = m_owner; n_age = m_age; n_ptr = m_ptr; n_dead = m_dead; n_forced = 1'b0;
        if (!rst_n) begin
            n_owner = -1; n_age = 0; n_ptr = 0; n_dead = 1'b0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] || m_age == MAX_HOLD) begin
                n_forced = bus.req[m_owner];
                n_ptr    = (m_owner + 1) % N;
                n_owner  = -1;
                n_age    = 0;
                n_dead   = 1'b1;
            end else begin
                n_age = m_age + 1;
            end
        end else if (m_dead) begin
            n_dead = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (n_owner < 0 && bus.req[c]) begin
                    n_owner = c;
                    n_age   = 1;
                end
            end
        end
        m_owner  <= n_owner;
        m_age    <= n_age;
        m_ptr    <= n_ptr;
        m_dead   <= n_dead;
        m_forced <= n_forced;
        if (!rst_n) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",     32'(bus.gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("gnt_idx", 32'(bus.gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("busy",    32'(bus.busy),    32'(m_owner >= 0));
            check("forced",  32'(bus.forced),  32'(m_forced));
        end
    end

    int rot_exp[5] = '{0, 1, 2, 3, 0};
    int order[$];
    int lens[$];
    int runlen;
    int nforced;
    bit prev_busy;
    bit seen;

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt",    32'(bus.gnt),    32'd0);
            check("rst_busy",   32'(bus.busy),   32'd0);
            check("rst_forced", 32'(bus.forced), 32'd0);
        end

        // Single request, then drop it.
        rst_n = 1'b1; bus.req = 4'b0100;
        @(negedge clk);
        check("single_gnt", 32'(bus.gnt),     32'h4);
        check("single_idx", 32'(bus.gnt_idx), 32'd2);
        bus.req = 4'b0000;
        @(negedge clk);
        check("single_drop_gnt", 32'(bus.gnt),    32'd0);
        check("single_drop_frc", 32'(bus.forced), 32'd0);
        @(negedge clk);
        check("single_idle_busy", 32'(bus.busy), 32'd0);

        // Rotation under full load with forced releases.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b1111;
        prev_busy = 1'b0; runlen = 0; nforced = 0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                order.push_back(int'(bus.gnt_idx));
                runlen = 0;
            end
            if (bus.busy) runlen++;
            if (!bus.busy && prev_busy) lens.push_back(runlen);
            if (bus.forced) nforced++;
            prev_busy = bus.busy;
        end
        check("rot_grants", 32'(order.size()), 32'd5);
        for (int k = 0; k < order.size() && k < 5; k++) check("rot_order", 32'(order[k]), 32'(rot_exp[k]));
        check("rot_nlen", 32'(lens.size()), 32'd4);
        for (int k = 0; k < lens.size(); k++) check("rot_len", 32'(lens[k]), 32'(MAX_HOLD));
        check("rot_forced", 32'(nforced), 32'd4);

        // Wrap: pointer at 3 after serving idx 2; idx 0 beats idx 1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b0100;
        @(negedge clk);
        check("wrap_first_idx", 32'(bus.gnt_idx), 32'd2);
        bus.req = 4'b0000;
        @(negedge clk);
        bus.req = 4'b0011;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = bus.busy;
        end
        check("wrap_seen", 32'(seen), 32'd1);
        check("wrap_idx",  32'(bus.gnt_idx), 32'd0);
        check("wrap_gnt",  32'(bus.gnt),     32'h1);

        // Reset in the middle of a grant.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b0010;
        repeat (3) @(negedge clk);
        check("mid_idx", 32'(bus.gnt_idx), 32'd1);
        rst_n = 1'b0; bus.req = 4'b0110;
        @(negedge clk);
        check("mid_rst_gnt",    32'(bus.gnt),    32'd0);
        check("mid_rst_forced", 32'(bus.forced), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_after_idx", 32'(bus.gnt_idx), 32'd1);
        check("mid_after_gnt", 32'(bus.gnt),     32'h2);

        // Request drops exactly when the hold limit is reached: normal release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b0001;
        repeat (MAX_HOLD) @(negedge clk);
        check("lim_busy", 32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        @(negedge clk);
        check("lim_forced", 32'(bus.forced), 32'd0);
        check("lim_busy2",  32'(bus.busy),   32'd0);

        // Randomized sticky requests with occasional resets.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) bus.req[b] = ~bus.req[b];
            rst_n = ($urandom_range(0, 99) != 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
